// File: rtl/timer_bank_if.sv
// Register bus between a CPU-side master and the timer bank slave.
interface timer_bank_if;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output rd, output wr, output addr, output wdata, input rdata);
   modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/timer_bank.sv
// Bank of NUM_CH independent up-counting timers with prescalers, reload on wrap,
// pending flags and a single maskable interrupt line.
module timer_bank #(
   parameter int          NUM_CH    = 4,
   parameter logic [31:0] BASE_ADDR = 32'h40000100,
   parameter int          PRE_W     = 16
) (
   input  logic        clk,
   input  logic        reset,
   timer_bank_if.slave bus,
   input  logic        PC31,
   output logic        irqout
);
   localparam logic [1:0]  REG_TH   = 2'd0;
   localparam logic [1:0]  REG_TL   = 2'd1;
   localparam logic [1:0]  REG_TCON = 2'd2;
   localparam logic [1:0]  REG_PRE  = 2'd3;
   localparam logic [31:0] IRQ_OFF  = 32'(16 * NUM_CH);

   logic [31:0]      thQ  [NUM_CH];
   logic [31:0]      thD  [NUM_CH];
   logic [31:0]      tlQ  [NUM_CH];
   logic [31:0]      tlD  [NUM_CH];
   logic [PRE_W-1:0] preQ [NUM_CH];
   logic [PRE_W-1:0] preD [NUM_CH];
   logic [PRE_W-1:0] pcQ  [NUM_CH];
   logic [PRE_W-1:0] pcD  [NUM_CH];
   logic [NUM_CH-1:0] enQ, enD, ienQ, ienD, pendQ, pendD, osQ, osD;
   logic [NUM_CH-1:0] tick, wrap, wrSel;

   logic [31:0] offset;
   logic        aligned, chHit, irqHit;
   logic [2:0]  selCh;
   logic [1:0]  selReg;

   // Offsets below BASE_ADDR wrap to huge values, so one compare covers both ends.
   assign offset  = bus.addr - BASE_ADDR;
   assign aligned = (bus.addr[1:0] == 2'b00);
   assign chHit   = aligned && (offset < IRQ_OFF);
   assign irqHit  = aligned && (offset == IRQ_OFF);
   assign selCh   = offset[6:4];
   assign selReg  = offset[3:2];

   always_comb begin
      tick  = '0;
      wrap  = '0;
      wrSel = '0;
      enD   = enQ;
      ienD  = ienQ;
      pendD = pendQ;
      osD   = osQ;
      for (int n = 0; n < NUM_CH; n++) begin
         thD[n]  = thQ[n];
         tlD[n]  = tlQ[n];
         preD[n] = preQ[n];
         pcD[n]  = pcQ[n];

         wrSel[n] = bus.wr && chHit && (selCh == 3'(n));
         tick[n]  = enQ[n] && (pcQ[n] == preQ[n]);
         wrap[n]  = tick[n] && (tlQ[n] == 32'hFFFFFFFF);

         if (!enQ[n] || tick[n]) pcD[n] = '0;
         else                    pcD[n] = pcQ[n] + PRE_W'(1);

         if (tick[n]) tlD[n] = wrap[n] ? thQ[n] : tlQ[n] + 32'd1;
         if (wrap[n] && osQ[n]) enD[n] = 1'b0;

         // Bus writes come after the count update so they take priority.
         if (wrSel[n]) begin
            case (selReg)
               REG_TH:   thD[n] = bus.wdata;
               REG_TL:   tlD[n] = bus.wdata;
               REG_TCON: begin
                  enD[n]  = bus.wdata[0];
                  ienD[n] = bus.wdata[1];
                  osD[n]  = bus.wdata[3];
                  if (bus.wdata[2]) pendD[n] = 1'b0;
               end
               REG_PRE:  begin
                  preD[n] = bus.wdata[PRE_W-1:0];
                  pcD[n]  = '0;
               end
               default: ;
            endcase
         end
         if (bus.wr && irqHit && bus.wdata[n]) pendD[n] = 1'b0;

         // A wrap event must never be lost to a software clear in the same cycle.
         if (wrap[n] && ienQ[n]) pendD[n] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int n = 0; n < NUM_CH; n++) begin
            thQ[n]  <= '0;
            tlQ[n]  <= '0;
            preQ[n] <= '0;
            pcQ[n]  <= '0;
         end
         enQ   <= '0;
         ienQ  <= '0;
         pendQ <= '0;
         osQ   <= '0;
      end else begin
         for (int n = 0; n < NUM_CH; n++) begin
            thQ[n]  <= thD[n];
            tlQ[n]  <= tlD[n];
            preQ[n] <= preD[n];
            pcQ[n]  <= pcD[n];
         end
         enQ   <= enD;
         ienQ  <= ienD;
         pendQ <= pendD;
         osQ   <= osD;
      end
   end

   always_comb begin
      bus.rdata = '0;
      if (bus.rd) begin
         if (irqHit) begin
            bus.rdata = 32'(pendQ);
         end else if (chHit) begin
            for (int n = 0; n < NUM_CH; n++) begin
               if (selCh == 3'(n)) begin
                  case (selReg)
                     REG_TH:   bus.rdata = thQ[n];
                     REG_TL:   bus.rdata = tlQ[n];
                     REG_TCON: bus.rdata = {28'd0, osQ[n], pendQ[n], ienQ[n], enQ[n]};
                     REG_PRE:  bus.rdata = 32'(preQ[n]);
                     default:  bus.rdata = '0;
                  endcase
               end
            end
         end
      end
   end

   assign irqout = ~PC31 & (|pendQ);
endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: constant vector table, hand-written corner
// sequences and a randomized run compared against a per-register reference model.
module tb_timer_bank;
   localparam int          NUM_CH   = 4;
   localparam logic [31:0] BASE     = 32'h40000100;
   localparam int          PRE_W    = 16;
   localparam logic [31:0] IRQ_ADDR = BASE + 32'(16 * NUM_CH);

   logic clk;
   logic reset;
   logic PC31;
   logic irqout;

   timer_bank_if bus ();

   timer_bank #(.NUM_CH(NUM_CH), .BASE_ADDR(BASE), .PRE_W(PRE_W)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus),
      .PC31   (PC31),
      .irqout (irqout)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int vectors = 0;
   int misses  = 0;

   typedef struct {
      string       name;
      logic        doWr;
      logic [31:0] wAddr;
      logic [31:0] wData;
      logic [31:0] rAddr;
      logic [31:0] expData;
   } vec_t;
   vec_t vecs[$];

   // Reference model: per-register state, updated from the bus at every clock edge.
   logic [31:0] mTh   [NUM_CH];
   logic [31:0] mTl   [NUM_CH];
   logic [31:0] mPre  [NUM_CH];
   logic [31:0] mDiv  [NUM_CH];
   bit          mEn   [NUM_CH];
   bit          mIen  [NUM_CH];
   bit          mPend [NUM_CH];
   bit          mOs   [NUM_CH];

   function automatic logic [31:0] regAddr(int ch, int r);
      return BASE + 32'(16 * ch + 4 * r);
   endfunction

   function automatic void modelReset();
      for (int n = 0; n < NUM_CH; n++) begin
         mTh[n] = 0; mTl[n] = 0; mPre[n] = 0; mDiv[n] = 0;
         mEn[n] = 0; mIen[n] = 0; mPend[n] = 0; mOs[n] = 0;
      end
   endfunction

   function automatic void modelStep(logic w, logic [31:0] a, logic [31:0] d);
      logic [31:0] off;
      int tgtCh, tgtReg;
      bit irqWr, fire, wrapped, oldIen;
      off = a - BASE;
      tgtCh = -1; tgtReg = -1; irqWr = 0;
      if (w && a[1:0] == 2'b00) begin
         if (off < 16 * NUM_CH) begin
            tgtCh  = int'(off / 16);
            tgtReg = int'((off % 16) / 4);
         end else if (off == 16 * NUM_CH) begin
            irqWr = 1;
         end
      end
      for (int n = 0; n < NUM_CH; n++) begin
         oldIen  = mIen[n];
         fire    = mEn[n] && (mDiv[n] == mPre[n]);
         wrapped = fire && (mTl[n] == 32'hFFFFFFFF);
         mDiv[n] = (mEn[n] && !fire) ? mDiv[n] + 32'd1 : 32'd0;
         if (fire) mTl[n] = wrapped ? mTh[n] : mTl[n] + 32'd1;
         if (wrapped && mOs[n]) mEn[n] = 0;
         if (tgtCh == n) begin
            case (tgtReg)
               0: mTh[n] = d;
               1: mTl[n] = d;
               2: begin
                  mEn[n] = d[0]; mIen[n] = d[1]; mOs[n] = d[3];
                  if (d[2]) mPend[n] = 0;
               end
               default: begin
                  mPre[n] = d & 32'h0000FFFF;
                  mDiv[n] = 0;
               end
            endcase
         end
         if (irqWr && d[n]) mPend[n] = 0;
         if (wrapped && oldIen) mPend[n] = 1;
      end
   endfunction

   function automatic logic [31:0] modelRead(logic [31:0] a);
      logic [31:0] off;
      logic [31:0] r;
      int ch;
      off = a - BASE;
      r = 0;
      if (a[1:0] != 2'b00) return 32'd0;
      if (off == 16 * NUM_CH) begin
         for (int n = 0; n < NUM_CH; n++) r[n] = mPend[n];
         return r;
      end
      if (off > 16 * NUM_CH) return 32'd0;
      ch = int'(off / 16);
      case (int'((off % 16) / 4))
         0: r = mTh[ch];
         1: r = mTl[ch];
         2: r = {28'd0, mOs[ch], mPend[ch], mIen[ch], mEn[ch]};
         default: r = mPre[ch];
      endcase
      return r;
   endfunction

   function automatic logic modelIrq();
      bit any;
      any = 0;
      for (int n = 0; n < NUM_CH; n++) any = any | mPend[n];
      return !PC31 && any;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) modelReset();
      else        modelStep(bus.wr, bus.addr, bus.wdata);
   end

   function automatic void addVec(string name, logic doWr, logic [31:0] wAddr,
                                  logic [31:0] wData, logic [31:0] rAddr, logic [31:0] expData);
      vec_t v;
      v.name = name; v.doWr = doWr; v.wAddr = wAddr; v.wData = wData;
      v.rAddr = rAddr; v.expData = expData;
      vecs.push_back(v);
   endfunction

   // One clock cycle with the given write (or idle when w=0).
   task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d);
      bus.wr = w; bus.rd = 1'b0; bus.addr = a; bus.wdata = d;
      @(posedge clk);
      #1;
      bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
   endtask

   task automatic checkOutput(input string name, input logic r, input logic [31:0] a,
                              input logic [31:0] expData, input logic expIrq);
      bus.rd = r; bus.wr = 1'b0; bus.addr = a;
      #1;
      vectors++;
      if (bus.rdata !== expData || irqout !== expIrq) begin
         misses++;
         $display("[TB] FAIL %s: rdata=%h irqout=%b, required rdata=%h irqout=%b",
                  name, bus.rdata, irqout, expData, expIrq);
      end
      bus.rd = 1'b0; bus.addr = '0;
   endtask

   task automatic doReset();
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] a, d;
      int kind, ch, rg;

      bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
      PC31 = 1'b0; reset = 1'b0;

      addVec("th0_rw",        1, regAddr(0,0), 32'hA5A5A5A5, regAddr(0,0), 32'hA5A5A5A5);
      addVec("tl1_rw",        1, regAddr(1,1), 32'h12345678, regAddr(1,1), 32'h12345678);
      addVec("pre2_trunc",    1, regAddr(2,3), 32'h00012345, regAddr(2,3), 32'h00002345);
      addVec("tcon3_bits",    1, regAddr(3,2), 32'hFFFFFFFE, regAddr(3,2), 32'h0000000A);
      addVec("tcon3_zero",    1, regAddr(3,2), 32'h00000000, regAddr(3,2), 32'h00000000);
      addVec("misalign_wr",   1, BASE + 32'd1, 32'hFFFFFFFF, regAddr(0,0), 32'hA5A5A5A5);
      addVec("misalign_rd",   0, 32'd0,        32'd0,        BASE + 32'd1, 32'h00000000);
      addVec("unmapped_wr",   1, IRQ_ADDR + 4, 32'hFFFFFFFF, regAddr(1,1), 32'h12345678);
      addVec("unmapped_rd",   0, 32'd0,        32'd0,        IRQ_ADDR + 4, 32'h00000000);
      addVec("irqstat_w1c",   1, IRQ_ADDR,     32'h000000FF, IRQ_ADDR,     32'h00000000);
      addVec("below_base",    1, BASE - 4,     32'h00000001, BASE - 4,     32'h00000000);
      addVec("th3_rw",        1, regAddr(3,0), 32'hDEADBEEF, regAddr(3,0), 32'hDEADBEEF);
      addVec("misalign2_wr",  1, BASE + 32'h32, 32'h00000000, regAddr(3,0), 32'hDEADBEEF);
      addVec("tl0_untouched", 0, 32'd0,        32'd0,        regAddr(0,1), 32'h00000000);

      // Reset state, with and without a read strobe
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_rd0",  1'b0, regAddr(0,1), 32'd0, 1'b0);
      checkOutput("reset_tcon", 1'b1, regAddr(1,2), 32'd0, 1'b0);
      reset = 1'b1;
      checkOutput("reset_irqstat", 1'b1, IRQ_ADDR, 32'd0, 1'b0);

      foreach (vecs[i]) begin
         if (vecs[i].doWr) applyStimulus(1'b1, vecs[i].wAddr, vecs[i].wData);
         checkOutput(vecs[i].name, 1'b1, vecs[i].rAddr, vecs[i].expData, 1'b0);
      end

      // Overflow with reload and interrupt masking
      doReset();
      applyStimulus(1'b1, regAddr(0,0), 32'hFFFFFFFD);
      applyStimulus(1'b1, regAddr(0,1), 32'hFFFFFFFD);
      applyStimulus(1'b1, regAddr(0,3), 32'h0);
      applyStimulus(1'b1, regAddr(0,2), 32'h3);
      checkOutput("ovf_tl_start", 1'b1, regAddr(0,1), 32'hFFFFFFFD, 1'b0);
      applyStimulus(1'b0, '0, '0);
      checkOutput("ovf_tl_1", 1'b1, regAddr(0,1), 32'hFFFFFFFE, 1'b0);
      applyStimulus(1'b0, '0, '0);
      checkOutput("ovf_tl_2", 1'b1, regAddr(0,1), 32'hFFFFFFFF, 1'b0);
      applyStimulus(1'b0, '0, '0);
      checkOutput("ovf_reload", 1'b1, regAddr(0,1), 32'hFFFFFFFD, 1'b1);
      checkOutput("ovf_tcon",   1'b1, regAddr(0,2), 32'h7, 1'b1);
      PC31 = 1'b1;
      checkOutput("ovf_masked", 1'b1, IRQ_ADDR, 32'h1, 1'b0);
      PC31 = 1'b0;

      // Set from overflow beats a same-cycle IRQSTAT clear
      applyStimulus(1'b0, '0, '0);
      applyStimulus(1'b0, '0, '0);
      applyStimulus(1'b1, IRQ_ADDR, 32'h1);
      checkOutput("pend_wins_irqstat", 1'b1, IRQ_ADDR, 32'h1, 1'b1);
      checkOutput("pend_wins_tl",      1'b1, regAddr(0,1), 32'hFFFFFFFD, 1'b1);
      applyStimulus(1'b1, IRQ_ADDR, 32'h1);
      checkOutput("irqstat_clear", 1'b1, IRQ_ADDR, 32'h0, 1'b0);
      applyStimulus(1'b1, regAddr(0,2), 32'h0);

      // Prescaler of 2 divides by three; TL write on a tick cycle wins
      applyStimulus(1'b1, regAddr(1,3), 32'd2);
      applyStimulus(1'b1, regAddr(1,1), 32'd0);
      applyStimulus(1'b1, regAddr(1,2), 32'd1);
      for (int i = 0; i < 7; i++) begin
         checkOutput("prescale_tl", 1'b1, regAddr(1,1), 32'(i / 3), 1'b0);
         if (i < 6) applyStimulus(1'b0, '0, '0);
      end
      applyStimulus(1'b0, '0, '0);
      applyStimulus(1'b0, '0, '0);
      applyStimulus(1'b1, regAddr(1,1), 32'd100);
      checkOutput("tl_wr_wins", 1'b1, regAddr(1,1), 32'd100, 1'b0);
      applyStimulus(1'b0, '0, '0);
      checkOutput("tl_wr_hold1", 1'b1, regAddr(1,1), 32'd100, 1'b0);
      applyStimulus(1'b0, '0, '0);
      checkOutput("tl_wr_hold2", 1'b1, regAddr(1,1), 32'd100, 1'b0);
      applyStimulus(1'b0, '0, '0);
      checkOutput("tl_wr_next", 1'b1, regAddr(1,1), 32'd101, 1'b0);
      applyStimulus(1'b1, regAddr(1,2), 32'h0);

      // One-shot stops after a single reload; clearing IEN keeps PEND
      applyStimulus(1'b1, regAddr(2,0), 32'd5);
      applyStimulus(1'b1, regAddr(2,1), 32'hFFFFFFFF);
      applyStimulus(1'b1, regAddr(2,2), 32'hB);
      checkOutput("oneshot_start", 1'b1, regAddr(2,1), 32'hFFFFFFFF, 1'b0);
      applyStimulus(1'b0, '0, '0);
      checkOutput("oneshot_tl",   1'b1, regAddr(2,1), 32'd5, 1'b1);
      checkOutput("oneshot_tcon", 1'b1, regAddr(2,2), 32'hE, 1'b1);
      applyStimulus(1'b0, '0, '0);
      checkOutput("oneshot_stays", 1'b1, regAddr(2,1), 32'd5, 1'b1);
      applyStimulus(1'b1, regAddr(2,2), 32'h0);
      checkOutput("ien_clear_keeps_pend", 1'b1, regAddr(2,2), 32'h4, 1'b1);
      applyStimulus(1'b1, regAddr(2,2), 32'h4);
      checkOutput("tcon_pend_clear", 1'b1, regAddr(2,2), 32'h0, 1'b0);

      // TCON write beats the one-shot EN clear on the wrap cycle
      applyStimulus(1'b1, regAddr(2,0), 32'd9);
      applyStimulus(1'b1, regAddr(2,1), 32'hFFFFFFFF);
      applyStimulus(1'b1, regAddr(2,2), 32'hB);
      applyStimulus(1'b1, regAddr(2,2), 32'hB);
      checkOutput("tcon_beats_oneshot", 1'b1, regAddr(2,2), 32'hF, 1'b1);
      checkOutput("tcon_beats_tl",      1'b1, regAddr(2,1), 32'd9, 1'b1);
      applyStimulus(1'b0, '0, '0);
      checkOutput("still_running", 1'b1, regAddr(2,1), 32'd10, 1'b1);
      applyStimulus(1'b1, regAddr(2,2), 32'h4);
      checkOutput("ch2_stopped", 1'b1, regAddr(2,2), 32'h0, 1'b0);

      // Overflow set beats a same-cycle TCON pend clear
      applyStimulus(1'b1, regAddr(3,1), 32'hFFFFFFFF);
      applyStimulus(1'b1, regAddr(3,2), 32'h3);
      applyStimulus(1'b1, regAddr(3,2), 32'h7);
      checkOutput("pend_wins_tcon", 1'b1, regAddr(3,2), 32'h7, 1'b1);
      checkOutput("ch3_reload",     1'b1, regAddr(3,1), 32'h0, 1'b1);
      applyStimulus(1'b1, regAddr(3,2), 32'h4);
      checkOutput("ch3_stopped", 1'b1, regAddr(3,2), 32'h0, 1'b0);

      // Reset mid-count aborts immediately and nothing ticks on release
      applyStimulus(1'b1, regAddr(0,1), 32'hFFFFFFFE);
      applyStimulus(1'b1, regAddr(0,2), 32'h3);
      checkOutput("pre_abort_tl", 1'b1, regAddr(0,1), 32'hFFFFFFFE, 1'b0);
      reset = 1'b0;
      checkOutput("abort_tl_async", 1'b1, regAddr(0,1), 32'h0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      checkOutput("abort_tcon", 1'b1, regAddr(0,2), 32'h0, 1'b0);
      applyStimulus(1'b0, '0, '0);
      checkOutput("release_no_tick", 1'b1, regAddr(0,1), 32'h0, 1'b0);
      checkOutput("release_no_pend", 1'b1, IRQ_ADDR, 32'h0, 1'b0);

      // Randomized traffic against the reference model
      doReset();
      for (int it = 0; it < 600; it++) begin
         PC31 = ($urandom_range(0, 3) == 0);
         ch = int'($urandom_range(0, NUM_CH - 1));
         rg = int'($urandom_range(0, 3));
         a  = ($urandom_range(0, 9) == 0) ? IRQ_ADDR : regAddr(ch, rg);
         checkOutput("rand_read", 1'b1, a, modelRead(a), modelIrq());
         if ($urandom_range(0, 99) < 35) begin
            kind = int'($urandom_range(0, 9));
            ch = int'($urandom_range(0, NUM_CH - 1));
            case (kind)
               0, 1: begin a = regAddr(ch, 1); d = 32'hFFFFFFFF - $urandom_range(0, 5); end
               2:    begin a = regAddr(ch, 0); d = $urandom; end
               3, 4: begin a = regAddr(ch, 2); d = $urandom_range(0, 15); end
               5:    begin a = regAddr(ch, 3); d = $urandom_range(0, 3) | ($urandom_range(0, 1) << 20); end
               6:    begin a = IRQ_ADDR;       d = $urandom_range(0, 15); end
               7:    begin a = regAddr(ch, int'($urandom_range(0, 3))) + $urandom_range(1, 3); d = $urandom; end
               default: begin a = regAddr(ch, 2); d = 32'h3 | ($urandom_range(0, 1) << 3); end
            endcase
            applyStimulus(1'b1, a, d);
         end else begin
            applyStimulus(1'b0, '0, '0);
         end
      end
      PC31 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end
endmodule
